// File: rtl/clock_mux_sw_pkg.sv
// Shared types and default constants for the clock-mux switch sequencer.
package clock_mux_sw_pkg;

   // Sequencer states, 3-bit encoding
   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StGateOff   = 3'd1,
      StWaitValid = 3'd2,
      StSwitch    = 3'd3,
      StSettle    = 3'd4,
      StAck       = 3'd5
   } sw_state_e;

   localparam int unsigned GateCyclesDef    = 4;
   localparam int unsigned SettleCyclesDef  = 8;
   localparam int unsigned TimeoutCyclesDef = 1024;

   // Largest of three cycle counts, used to size the shared timer
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/clock_mux_sw_timer.sv
// Loadable saturating down-counter with zero flag, shared by the sequencer's timed states.
module clock_mux_sw_timer #(
   parameter int unsigned CntW = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic [CntW-1:0] i_load_val,
   output logic            o_zero
);

   logic [CntW-1:0] r_cnt;

   // Load takes priority; otherwise count down and hold at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (!o_zero) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clock_mux_switch_ctrl.sv
// Glitch-free switch sequencer for a two-input clock mux: gate off, wait for the target
// source, switch select, settle, gate on, with a 4-phase req/ack handshake.
// Optional feature macro: CLOCK_MUX_SW_TIMEOUT_EN (bounded WAIT_VALID with sticky err_o).
module clock_mux_switch_ctrl
   import clock_mux_sw_pkg::*;
#(
   parameter int unsigned GateCycles    = GateCyclesDef,
   parameter int unsigned SettleCycles  = SettleCyclesDef,
   parameter int unsigned TimeoutCycles = TimeoutCyclesDef
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sw_req_i,
   input  logic       sw_sel_i,
   input  logic [1:0] src_valid_i,
   output logic       sw_ack_o,
   output logic       busy_o,
   output logic       sel_o,
   output logic       clk_en_o,
   output logic       err_o
);

   localparam int unsigned CntW = $clog2(max3(GateCycles, SettleCycles, TimeoutCycles)) + 1;

   sw_state_e       r_state;
   logic            r_tgt;
   logic            r_sel;
   logic            r_clk_en;
   logic            r_ack;
   logic            r_busy;
   logic            w_load;
   logic [CntW-1:0] w_load_val;
   logic            w_zero;
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
   logic            r_err;
`endif

   // Timer reloads on entry to each timed state
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      unique case (r_state)
         StIdle: begin
            if (sw_req_i && !r_ack && (sw_sel_i != r_sel)) begin
               w_load     = 1'b1;
               w_load_val = CntW'(GateCycles - 1);
            end
         end
         StSwitch: begin
            w_load     = 1'b1;
            w_load_val = CntW'(SettleCycles - 1);
         end
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
         StGateOff: begin
            if (w_zero) begin
               w_load     = 1'b1;
               w_load_val = CntW'(TimeoutCycles - 1);
            end
         end
`endif
         default: ;
      endcase
   end

   clock_mux_sw_timer #(
      .CntW (CntW)
   ) u_timer (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   // Sequencer FSM with all outputs registered alongside the state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= StIdle;
         r_tgt    <= 1'b0;
         r_sel    <= 1'b0;
         r_clk_en <= 1'b1;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
         r_err    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               // A held request only re-arms after the previous ack has been dropped
               if (sw_req_i && !r_ack) begin
                  r_tgt  <= sw_sel_i;
                  r_busy <= 1'b1;
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
                  r_err  <= 1'b0;
`endif
                  if (sw_sel_i == r_sel) begin
                     r_ack   <= 1'b1;
                     r_state <= StAck;
                  end else begin
                     r_clk_en <= 1'b0;
                     r_state  <= StGateOff;
                  end
               end
            end
            StGateOff: begin
               if (w_zero) r_state <= StWaitValid;
            end
            StWaitValid: begin
               if (src_valid_i[r_tgt]) begin
                  r_sel   <= r_tgt;
                  r_state <= StSwitch;
               end
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
               else if (w_zero) begin
                  // Abandon the switch: keep the old source and reopen the gate
                  r_clk_en <= 1'b1;
                  r_err    <= 1'b1;
                  r_ack    <= 1'b1;
                  r_state  <= StAck;
               end
`endif
            end
            StSwitch: begin
               r_state <= StSettle;
            end
            StSettle: begin
               if (w_zero) begin
                  r_clk_en <= 1'b1;
                  r_ack    <= 1'b1;
                  r_state  <= StAck;
               end
            end
            StAck: begin
               if (!sw_req_i) begin
                  r_ack   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sw_ack_o = r_ack;
   assign busy_o   = r_busy;
   assign sel_o    = r_sel;
   assign clk_en_o = r_clk_en;
`ifdef CLOCK_MUX_SW_TIMEOUT_EN
   assign err_o    = r_err;
`else
   assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mux_switch_ctrl.sv
// Directed bench for clock_mux_switch_ctrl with a request/ack scoreboard.
`timescale 1ns/1ps
module tb_clock_mux_switch_ctrl;

   localparam int G = 4;
   localparam int S = 8;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       sw_req_i = 1'b0;
   logic       sw_sel_i = 1'b0;
   logic [1:0] src_valid_i = 2'b11;
   logic       sw_ack_o, busy_o, sel_o, clk_en_o, err_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      string tag;
      int    t0;
      int    lat;
      logic  sel;
      logic  err;
      bit    gated;
   } sb_t;
   sb_t sb_q[$];

   // Monitor state (written only by the monitor process)
   bit   mon_on = 1'b0;
   int   mon_viol = 0;
   int   en_falls = 0;
   int   low_len = 0;
   int   last_low = 0;
   logic prev_sel = 1'b0;
   logic prev_en = 1'b1;

   clock_mux_switch_ctrl #(
      .GateCycles    (G),
      .SettleCycles  (S),
      .TimeoutCycles (T)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .sw_req_i    (sw_req_i),
      .sw_sel_i    (sw_sel_i),
      .src_valid_i (src_valid_i),
      .sw_ack_o    (sw_ack_o),
      .busy_o      (busy_o),
      .sel_o       (sel_o),
      .clk_en_o    (clk_en_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   // Select must never move while the downstream gate is open; track gate-low spans
   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         if (sel_o !== prev_sel && (prev_en || clk_en_o)) mon_viol++;
         if (prev_en && !clk_en_o) en_falls++;
      end
      if (!clk_en_o) begin
         low_len++;
      end else begin
         if (low_len != 0) last_low = low_len;
         low_len = 0;
      end
      prev_sel = sel_o;
      prev_en  = clk_en_o;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic request(input string tag, input logic sel, input int lat, input logic exp_sel,
                          input logic exp_err, input bit gated);
      sb_t e;
      sw_sel_i = sel;
      sw_req_i = 1'b1;
      e.tag = tag; e.t0 = cyc; e.lat = lat; e.sel = exp_sel; e.err = exp_err; e.gated = gated;
      sb_q.push_back(e);
   endtask

   task automatic wait_ack(input int budget);
      sb_t e;
      int  k;
      k = 0;
      while (sw_ack_o !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      e = sb_q.pop_front();
      chk({e.tag, "_ack"}, {31'd0, sw_ack_o}, 32'd1);
      chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
      chk({e.tag, "_sel"}, {31'd0, sel_o}, {31'd0, e.sel});
      chk({e.tag, "_en"}, {31'd0, clk_en_o}, 32'd1);
      chk({e.tag, "_err"}, {31'd0, err_o}, {31'd0, e.err});
      if (e.gated) chk({e.tag, "_gate_len"}, (last_low >= G + S + 1) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic release_req(input string tag);
      sw_req_i = 1'b0;
      step();
      chk({tag, "_ack_drop"}, {31'd0, sw_ack_o}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      int falls0;

      // Reset values
      step(); step();
      chk("rst_sel", {31'd0, sel_o}, 32'd0);
      chk("rst_en", {31'd0, clk_en_o}, 32'd1);
      chk("rst_ack", {31'd0, sw_ack_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      rst_ni = 1'b1;
      step(); step();
      mon_on = 1'b1;

      // Same-target request: immediate ack, gate untouched
      falls0 = en_falls;
      request("t2", 1'b0, 1, 1'b0, 1'b0, 1'b0);
      wait_ack(10);
      chk("t2_no_gate", en_falls - falls0, 0);
      release_req("t2");

      // Switch 0->1 with both sources valid
      src_valid_i = 2'b11;
      request("t1", 1'b1, G + S + 3, 1'b1, 1'b0, 1'b1);
      step();
      chk("t1_en_drop", {31'd0, clk_en_o}, 32'd0);
      chk("t1_busy", {31'd0, busy_o}, 32'd1);
      repeat (G) step();
      chk("t1_sel_hold", {31'd0, sel_o}, 32'd0);
      step();
      chk("t1_sel_flip", {31'd0, sel_o}, 32'd1);
      chk("t1_en_low_at_flip", {31'd0, clk_en_o}, 32'd0);
      wait_ack(40);
      release_req("t1");

      // Target sel toggled and req dropped mid GATE_OFF: original target, one-cycle ack
      request("t6", 1'b0, G + S + 3, 1'b0, 1'b0, 1'b1);
      step(); step();
      sw_sel_i = 1'b1;
      sw_req_i = 1'b0;
      wait_ack(40);
      step();
      chk("t6_ack_pulse", {31'd0, sw_ack_o}, 32'd0);
      chk("t6_idle", {31'd0, busy_o}, 32'd0);
      chk("t6_sel_kept", {31'd0, sel_o}, 32'd0);

      // Target source not ready for 50 cycles
      src_valid_i = 2'b01;
      request("t3", 1'b1, 60, 1'b1, 1'b0, 1'b1);
      repeat (50) step();
      chk("t3_wait_en", {31'd0, clk_en_o}, 32'd0);
      chk("t3_wait_sel", {31'd0, sel_o}, 32'd0);
      chk("t3_wait_busy", {31'd0, busy_o}, 32'd1);
      src_valid_i = 2'b11;
      step();
      chk("t3_sel_flip", {31'd0, sel_o}, 32'd1);
      wait_ack(40);
      release_req("t3");

      // Switch back 1->0
      request("back", 1'b0, G + S + 3, 1'b0, 1'b0, 1'b1);
      wait_ack(40);
      release_req("back");

      // Asynchronous reset during SETTLE
      request("t5", 1'b1, 0, 1'b1, 1'b0, 1'b1);
      repeat (10) step();
      chk("t5_settle_sel", {31'd0, sel_o}, 32'd1);
      chk("t5_settle_en", {31'd0, clk_en_o}, 32'd0);
      mon_on = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("t5_rst_sel", {31'd0, sel_o}, 32'd0);
      chk("t5_rst_en", {31'd0, clk_en_o}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_rst_ack", {31'd0, sw_ack_o}, 32'd0);
      sb_q.delete();
      sw_req_i = 1'b0;
      step(); step();
      rst_ni = 1'b1;
      step(); step();
      mon_on = 1'b1;

`ifdef CLOCK_MUX_SW_TIMEOUT_EN
      // Target never becomes valid: timeout, select unchanged, sticky error
      src_valid_i = 2'b01;
      request("t4", 1'b1, G + T + 1, 1'b0, 1'b1, 1'b1);
      wait_ack(80);
      release_req("t4");
      chk("t4_err_sticky", {31'd0, err_o}, 32'd1);
      request("t4_clr", 1'b0, 1, 1'b0, 1'b0, 1'b0);
      wait_ack(10);
      release_req("t4_clr");
      src_valid_i = 2'b11;
`endif

      chk("inv_sel_stable_while_en", mon_viol, 0);
      chk("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
